// File: rtl/pipe_share_arbiter.sv
// Round-robin share of a 2-stage registered pipe between NREQ requesters; 2 edges capture-to-out.
// No backpressure from downstream; a global stall freezes grants, both stages, ptr and FSM.
module pipe_share_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic                  stall,
   output logic [NREQ-1:0]       gnt,
   output logic                  s1_valid,
   output logic [WIDTH-1:0]      s1_data,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [IDW-1:0]        out_id,
   output logic                  busy
);

   generate
      if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
         $error("pipe_share_arbiter: NREQ must be in 2..8");
      end
      if (IDW != $clog2(NREQ)) begin : g_bad_idw
         $error("pipe_share_arbiter: IDW must equal clog2(NREQ)");
      end
   endgenerate

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   ptr_nxt;
   logic [IDW-1:0]   gidx;
   logic [IDW-1:0]   cand;
   logic [IDW:0]     sum;
   logic             hit;
   logic             grant;
   logic [WIDTH-1:0] gdata;
   logic [IDW-1:0]   s1_id;
   logic [1:0]       state;
   logic [1:0]       state_nxt;

   // Scan upward from ptr with wrap; the first requesting index wins.
   always_comb begin
      hit  = 1'b0;
      gidx = '0;
      sum  = '0;
      cand = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
         end
         cand = sum[IDW-1:0];
         if (!hit && req[cand]) begin
            hit  = 1'b1;
            gidx = cand;
         end
      end
   end

   always_comb begin
      grant   = hit & ~stall & ~rst;
      gnt     = grant ? (NREQ'(1) << gidx) : '0;
      gdata   = req_data[int'(gidx)*WIDTH +: WIDTH];
      ptr_nxt = (gidx == LAST_ID) ? '0 : gidx + 1'b1;
   end

   // DRAIN looks at the stage valids as they will be after this edge.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (|req) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (~|req) state_nxt = (s1_valid | out_valid) ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (|req)                    state_nxt = ST_RUN;
            else if (!grant && !s1_valid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s1_id     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
         state     <= ST_IDLE;
      end else if (!stall) begin
         s1_valid  <= grant;
         if (grant) begin
            s1_data <= gdata;
            s1_id   <= gidx;
            ptr     <= ptr_nxt;
         end
         out_valid <= s1_valid;
         out_data  <= s1_data;
         out_id    <= s1_id;
         state     <= state_nxt;
      end
   end

   assign busy = (state != ST_IDLE);

   a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter: reset, single, rotation, wrap, stall, async reset.
module tb_pipe_share_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic        stall;
   logic [3:0]  gnt;
   logic        s1_valid;
   logic [7:0]  s1_data;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_id;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] w [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

   pipe_share_arbiter #(.WIDTH(8), .NREQ(4), .IDW(2)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .stall(stall),
      .gnt(gnt), .s1_valid(s1_valid), .s1_data(s1_data), .out_valid(out_valid),
      .out_data(out_data), .out_id(out_id), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; stall = 1'b0; req_data = '0;
      for (int c = 0; c < 2; c++) begin
         step();
         vectors++;
         if ({gnt, s1_valid, s1_data, out_valid, out_data, out_id, busy} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_hold got=%h exp=0", {gnt, s1_valid, s1_data, out_valid, out_data, out_id, busy});
         end
      end
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         vectors++;
         if ({gnt, s1_valid, s1_data, out_valid, out_data, out_id, busy} !== 25'd0) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%h exp=0", {gnt, s1_valid, s1_data, out_valid, out_data, out_id, busy});
         end
      end
   endtask

   task automatic test_single();
      req_data = 32'h0000_005A; req = 4'b0001;
      #1;
      vectors++;
      if (gnt !== 4'b0001) begin
         miscompares++; $display("FAIL single_gnt got=%b exp=0001", gnt);
      end
      step();
      vectors++;
      if ({s1_valid, s1_data, out_valid, busy} !== {1'b1, 8'h5A, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL single_s1 got v=%b d=%h ov=%b busy=%b exp v=1 d=5a ov=0 busy=1", s1_valid, s1_data, out_valid, busy);
      end
      req = '0;
      #1;
      vectors++;
      if (gnt !== 4'b0000) begin
         miscompares++; $display("FAIL single_nogrant got=%b exp=0000", gnt);
      end
      step();
      vectors++;
      if ({s1_valid, out_valid, out_data, out_id, busy} !== {1'b0, 1'b1, 8'h5A, 2'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL single_out got s1v=%b ov=%b d=%h id=%0d busy=%b exp s1v=0 ov=1 d=5a id=0 busy=1", s1_valid, out_valid, out_data, out_id, busy);
      end
      step();
      vectors++;
      if ({s1_valid, out_valid, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL single_idle got s1v=%b ov=%b busy=%b exp 000", s1_valid, out_valid, busy);
      end
   endtask

   task automatic test_round_robin();
      rst = 1'b1; #1; rst = 1'b0;
      req_data = {w[3], w[2], w[1], w[0]}; req = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         #1;
         vectors++;
         if (gnt !== 4'(1 << (c % 4))) begin
            miscompares++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, gnt, 4'(1 << (c % 4)));
         end
         step();
         vectors++;
         if ({s1_valid, s1_data} !== {1'b1, w[c % 4]}) begin
            miscompares++; $display("FAIL rr_s1[%0d] got v=%b d=%h exp v=1 d=%h", c, s1_valid, s1_data, w[c % 4]);
         end
         vectors++;
         if (c == 0) begin
            if (out_valid !== 1'b0) begin
               miscompares++; $display("FAIL rr_out_first got ov=%b exp 0", out_valid);
            end
         end else if ({out_valid, out_data, out_id} !== {1'b1, w[(c-1) % 4], 2'((c-1) % 4)}) begin
            miscompares++;
            $display("FAIL rr_out[%0d] got v=%b d=%h id=%0d exp v=1 d=%h id=%0d", c, out_valid, out_data, out_id, w[(c-1) % 4], (c-1) % 4);
         end
      end
      req = '0;
      step();
      vectors++;
      if ({s1_valid, out_valid, out_data, out_id, busy} !== {1'b0, 1'b1, 8'h10, 2'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL rr_tail got s1v=%b ov=%b d=%h id=%0d busy=%b exp 0 1 10 0 1", s1_valid, out_valid, out_data, out_id, busy);
      end
      step();
      vectors++;
      if ({out_valid, busy} !== 2'b00) begin
         miscompares++; $display("FAIL rr_idle got ov=%b busy=%b exp 00", out_valid, busy);
      end
   endtask

   // Entered with ptr=1: a grant to 2 sets ptr=3, then 0101 must wrap to 0 and skip to 2.
   task automatic test_ptr_wrap();
      req_data = 32'h00C2_00A0; req = 4'b0100;
      #1;
      vectors++;
      if (gnt !== 4'b0100) begin
         miscompares++; $display("FAIL wrap_setup_gnt got=%b exp=0100", gnt);
      end
      step();
      req = 4'b0101;
      #1;
      vectors++;
      if (gnt !== 4'b0001) begin
         miscompares++; $display("FAIL wrap_ptr3_gnt got=%b exp=0001", gnt);
      end
      step();
      vectors++;
      if ({s1_data, out_data, out_id} !== {8'hA0, 8'hC2, 2'd2}) begin
         miscompares++; $display("FAIL wrap_pipe1 got s1=%h od=%h id=%0d exp a0 c2 2", s1_data, out_data, out_id);
      end
      #1;
      vectors++;
      if (gnt !== 4'b0100) begin
         miscompares++; $display("FAIL wrap_ptr1_gnt got=%b exp=0100", gnt);
      end
      step();
      vectors++;
      if ({s1_data, out_data, out_id} !== {8'hC2, 8'hA0, 2'd0}) begin
         miscompares++; $display("FAIL wrap_pipe2 got s1=%h od=%h id=%0d exp c2 a0 0", s1_data, out_data, out_id);
      end
      req = '0;
      step();
      vectors++;
      if ({out_valid, out_data, out_id} !== {1'b1, 8'hC2, 2'd2}) begin
         miscompares++; $display("FAIL wrap_tail got ov=%b d=%h id=%0d exp 1 c2 2", out_valid, out_data, out_id);
      end
      step();
   endtask

   // Entered with ptr=3.
   task automatic test_stall();
      req_data = {w[3], w[2], w[1], w[0]}; req = 4'b1111;
      step();
      step();
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (gnt !== 4'b0000) begin
            miscompares++; $display("FAIL stall_gnt[%0d] got=%b exp=0000", c, gnt);
         end
         step();
         vectors++;
         if ({s1_valid, s1_data, out_valid, out_data, out_id, busy} !== {1'b1, 8'h10, 1'b1, 8'h43, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_hold[%0d] got s1v=%b s1=%h ov=%b od=%h id=%0d busy=%b exp 1 10 1 43 3 1", c, s1_valid, s1_data, out_valid, out_data, out_id, busy);
         end
      end
      stall = 1'b0;
      #1;
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++; $display("FAIL stall_resume_gnt got=%b exp=0010", gnt);
      end
      step();
      vectors++;
      if ({s1_data, out_valid, out_data, out_id} !== {8'h21, 1'b1, 8'h10, 2'd0}) begin
         miscompares++; $display("FAIL stall_resume1 got s1=%h ov=%b od=%h id=%0d exp 21 1 10 0", s1_data, out_valid, out_data, out_id);
      end
      step();
      vectors++;
      if ({s1_data, out_data, out_id} !== {8'h32, 8'h21, 2'd1}) begin
         miscompares++; $display("FAIL stall_resume2 got s1=%h od=%h id=%0d exp 32 21 1", s1_data, out_data, out_id);
      end
      req = '0;
      step();
      step();
      vectors++;
      if ({s1_valid, out_valid, busy} !== 3'b000) begin
         miscompares++; $display("FAIL stall_idle got s1v=%b ov=%b busy=%b exp 000", s1_valid, out_valid, busy);
      end
   endtask

   task automatic test_async_reset();
      req_data = {w[3], w[2], w[1], w[0]}; req = 4'b1111;
      step();
      step();
      vectors++;
      if ({s1_valid, out_valid} !== 2'b11) begin
         miscompares++; $display("FAIL arst_setup got s1v=%b ov=%b exp 11", s1_valid, out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if ({gnt, s1_valid, s1_data, out_valid, out_data, out_id, busy} !== 25'd0) begin
         miscompares++;
         $display("FAIL arst_immediate got=%h exp=0", {gnt, s1_valid, s1_data, out_valid, out_data, out_id, busy});
      end
      step();
      vectors++;
      if ({gnt, s1_valid, out_valid, busy} !== 7'd0) begin
         miscompares++; $display("FAIL arst_held got gnt=%b s1v=%b ov=%b busy=%b exp 0", gnt, s1_valid, out_valid, busy);
      end
      #2;
      rst = 1'b0; req = 4'b0110;
      #1;
      vectors++;
      if (gnt !== 4'b0010) begin
         miscompares++; $display("FAIL arst_first_gnt got=%b exp=0010", gnt);
      end
      step();
      vectors++;
      if ({s1_valid, s1_data} !== {1'b1, 8'h21}) begin
         miscompares++; $display("FAIL arst_first_s1 got v=%b d=%h exp 1 21", s1_valid, s1_data);
      end
   endtask

   // A lone requester held high must win every cycle with no bubbles.
   task automatic test_back_to_back();
      req = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (gnt !== 4'b0010) begin
            miscompares++; $display("FAIL b2b_gnt[%0d] got=%b exp=0010", c, gnt);
         end
         step();
         vectors++;
         if ({s1_valid, s1_data, out_valid, out_data, out_id} !== {1'b1, 8'h21, 1'b1, 8'h21, 2'd1}) begin
            miscompares++;
            $display("FAIL b2b_pipe[%0d] got s1v=%b s1=%h ov=%b od=%h id=%0d exp 1 21 1 21 1", c, s1_valid, s1_data, out_valid, out_data, out_id);
         end
      end
      req = '0;
      step();
      step();
      vectors++;
      if ({s1_valid, out_valid, busy} !== 3'b000) begin
         miscompares++; $display("FAIL b2b_idle got s1v=%b ov=%b busy=%b exp 000", s1_valid, out_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_ptr_wrap();
      test_stall();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
